// File: rtl/s2p_pkg.sv
// Shared types and defaults for the serial-to-parallel design.
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } s2p_state_e;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/s2p_sync2.sv
// Generic 2-flop synchroniser with a configurable reset value.
module s2p_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/s2p_uart_deserializer.sv
// Start/stop-framed serial receiver: mid-bit sampling, one word per frame.
module s2p_uart_deserializer
  import s2p_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              CLOCK_50_B5B,
  input  logic              RESET,
  input  logic              SER_IN,
  output logic [DATA_W-1:0] PAR_OUT,
  output logic              PAR_VALID,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  logic              rx;
  logic              rx_d;
  s2p_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [DATA_W-1:0] par_next;
  logic              valid_next;
  logic              err_next;
  logic              busy_next;

  // Line idles high, so both stages reset to 1 to avoid a fake start edge.
  s2p_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (CLOCK_50_B5B),
    .rst (RESET),
    .d   (SER_IN),
    .q   (rx)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (RESET) begin
      rx_d      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      PAR_OUT   <= '0;
      PAR_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      rx_d      <= rx;
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shreg     <= shreg_next;
      PAR_OUT   <= par_next;
      PAR_VALID <= valid_next;
      FRAME_ERR <= err_next;
      BUSY      <= busy_next;
    end
  end

  // Next-state, counter, shift register and strobe decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    par_next   = PAR_OUT;
    valid_next = 1'b0;
    err_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_d && !rx) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (!rx) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          // Shift right then overwrite the MSB; valid for any DATA_W >= 1.
          shreg_next = shreg >> 1;
          shreg_next[DATA_W-1] = rx;
          idx_next   = idx + IDX_W'(1);
          if (idx == IDX_LAST) state_next = STOP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx) begin
            par_next   = shreg;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    // Held one extra cycle on the way back to IDLE so BUSY drops after the strobe/abort.
    busy_next = (state != IDLE) || (state_next != IDLE);
  end

endmodule

// File: tb/tb_s2p_uart_deserializer.sv
// Directed bench for s2p_uart_deserializer (DATA_W=8, CLKS_PER_BIT=8).
module tb_s2p_uart_deserializer;

  localparam int DW  = 8;
  localparam int CPB = 8;
  localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB;  // 78

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ser = 1'b1;
  logic [DW-1:0] par_out;
  logic          par_valid;
  logic          frame_err;
  logic          busy;

  s2p_uart_deserializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50_B5B (clk),
    .RESET        (rst),
    .SER_IN       (ser),
    .PAR_OUT      (par_out),
    .PAR_VALID    (par_valid),
    .FRAME_ERR    (frame_err),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            is_valid;
    logic [DW-1:0] par;
    logic          busy_next;
  } ev_t;

  ev_t evq[$];
  bit  pend_busy = 0;
  bit  prev_strobe = 0;
  int  busy_hi = 0;
  int  viol = 0;

  // Strobe logger and protocol watcher, sampled on the falling edge.
  always @(negedge clk) begin
    bit s;
    if (pend_busy && evq.size() > 0) evq[evq.size()-1].busy_next = busy;
    pend_busy = 0;
    if (busy === 1'b1) busy_hi++;
    s = (par_valid === 1'b1) || (frame_err === 1'b1);
    if (par_valid === 1'b1 && frame_err === 1'b1) viol++;
    if (s && prev_strobe) viol++;
    prev_strobe = s;
    if (s) begin
      evq.push_back('{cyc, par_valid === 1'b1, par_out, 1'bx});
      pend_busy = 1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; returns the cycle at which sync flop 1 captures the start bit.
  // The line is left at the stop-bit level.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, output int start_cyc);
    ser = 1'b0;
    start_cyc = cyc + 1;
    cycles(CPB);
    for (int unsigned i = 0; i < DW; i++) begin
      ser = d[i];
      cycles(CPB);
    end
    ser = stop_bit;
    cycles(CPB);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          stop_bit;
    logic [DW-1:0] exp_par;
    bit            exp_valid;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int st, st2;
    string nm;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 8'h81, 1'b0};
    vecs[6] = '{8'h5A, 1'b1, 8'h5A, 1'b1};

    // Reset and idle line.
    cycles(4);
    rst = 1'b0;
    cycles(1);
    check("reset_par_out", int'(par_out), 0);
    check("reset_par_valid", int'(par_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    busy_hi = 0;
    evq.delete();
    cycles(200);
    check("idle_strobes", evq.size(), 0);
    check("idle_busy_cycles", busy_hi, 0);

    // Table of single frames separated by an idle gap.
    for (int unsigned v = 0; v < 7; v++) begin
      evq.delete();
      send_frame(vecs[v].data, vecs[v].stop_bit, st);
      ser = 1'b1;
      cycles(20);
      nm = $sformatf("vec%0d", v);
      check({nm, "_events"}, evq.size(), 1);
      if (evq.size() >= 1) begin
        check({nm, "_kind_valid"}, int'(evq[0].is_valid), int'(vecs[v].exp_valid));
        check({nm, "_latency"}, evq[0].cyc - st, LAT);
        check({nm, "_busy_after"}, int'(evq[0].busy_next), 0);
      end
      check({nm, "_par_out"}, int'(par_out), int'(vecs[v].exp_par));
    end

    // Back-to-back frames with an 8-cycle stop bit.
    evq.delete();
    send_frame(8'h3C, 1'b1, st);
    send_frame(8'h81, 1'b1, st2);
    ser = 1'b1;
    cycles(20);
    check("b2b_events", evq.size(), 2);
    if (evq.size() == 2) begin
      check("b2b_first_valid", int'(evq[0].is_valid), 1);
      check("b2b_first_par", int'(evq[0].par), 8'h3C);
      check("b2b_first_latency", evq[0].cyc - st, LAT);
      check("b2b_second_valid", int'(evq[1].is_valid), 1);
      check("b2b_second_par", int'(evq[1].par), 8'h81);
      check("b2b_second_latency", evq[1].cyc - st2, LAT);
    end

    // Frame error followed by a break: no retrigger until a fresh falling edge.
    evq.delete();
    send_frame(8'hFF, 1'b0, st);
    busy_hi = 0;
    cycles(100);
    check("break_events", evq.size(), 1);
    if (evq.size() >= 1) begin
      check("break_is_err", int'(evq[0].is_valid), 0);
      check("break_latency", evq[0].cyc - st, LAT);
    end
    check("break_par_kept", int'(par_out), 8'h81);
    check("break_busy_cycles", busy_hi, 0);
    ser = 1'b1;
    cycles(20);
    check("break_release_events", evq.size(), 1);
    evq.delete();
    send_frame(8'hC3, 1'b1, st);
    ser = 1'b1;
    cycles(20);
    check("after_break_events", evq.size(), 1);
    check("after_break_par", int'(par_out), 8'hC3);

    // Two-cycle low glitch on an idle line.
    evq.delete();
    busy_hi = 0;
    ser = 1'b0;
    cycles(2);
    ser = 1'b1;
    cycles(30);
    check("glitch_strobes", evq.size(), 0);
    check("glitch_busy_cycles", busy_hi, 5);
    check("glitch_busy_end", int'(busy), 0);

    // One-cycle reset during data bit 4 of 0xF3 (bits 4..7 high, so no edge afterwards).
    evq.delete();
    ser = 1'b0;
    cycles(CPB);
    for (int unsigned i = 0; i < DW; i++) begin
      ser = (8'hF3 >> i) & 1'b1;
      if (i == 4) begin
        cycles(4);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midreset_busy", int'(busy), 0);
        check("midreset_par_out", int'(par_out), 0);
        cycles(CPB - 5);
      end else begin
        cycles(CPB);
      end
    end
    ser = 1'b1;
    cycles(100);
    check("midreset_strobes", evq.size(), 0);
    check("midreset_par_hold", int'(par_out), 0);
    send_frame(8'h5A, 1'b1, st);
    ser = 1'b1;
    cycles(20);
    check("midreset_next_events", evq.size(), 1);
    if (evq.size() >= 1) check("midreset_next_latency", evq[0].cyc - st, LAT);
    check("midreset_next_par", int'(par_out), 8'h5A);

    check("strobe_protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/s2p_uart_deserializer.md
# s2p_uart_deserializer

Receives an asynchronous, start/stop-framed serial bit stream and reassembles it into parallel words for the serial-to-parallel top level. It sits between the board input pin (a GPIO or switch line) and the top level's display logic, which drives LEDR/LEDG and HEX0. It synchronises the line, oversamples each bit at mid-period, and emits one validated word per frame with a single-cycle strobe. Malformed frames raise an error strobe.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); must be ≥ 4.

Ports:
- CLOCK_50_B5B  in  1  system clock, 50 MHz; the only clock.
- RESET  in  1  reset, synchronous and active-high.
- SER_IN  in  1  asynchronous serial line; idles high.
- PAR_OUT  out  DATA_W  last correctly received word; holds its value between frames.
- PAR_VALID  out  1  one-cycle strobe; PAR_OUT was updated this cycle.
- FRAME_ERR  out  1  one-cycle strobe; the stop bit was sampled low.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Frame format: start bit (low), then DATA_W data bits LSB first, then one stop bit (high).
- SER_IN passes through a 2-flop synchroniser. The rest of the logic uses only the synchronised bit `rx` and its one-cycle-delayed copy `rx_d`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rx_d`=1 and `rx`=0 (falling edge), clear the bit-period counter and go to START.
  - START: count floor(CLKS_PER_BIT/2) cycles. At terminal count, if `rx`=0, reload the counter and go to DATA. If `rx`=1, treat the edge as a glitch and return to IDLE with no strobe.
  - DATA: every CLKS_PER_BIT cycles, shift `rx` into the MSB of the shift register (right shift) and increment the bit index. After the sample with index DATA_W-1, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx`.
    - `rx`=1: load PAR_OUT from the shift register and pulse PAR_VALID.
    - `rx`=0: pulse FRAME_ERR and leave PAR_OUT unchanged.
    - Either way, go to IDLE on the next cycle.
- A new frame always needs a fresh falling edge. A line held low after a frame error (break) never retriggers the receiver.
- PAR_VALID and FRAME_ERR are mutually exclusive and are never high for two consecutive cycles.
- Reset values: state IDLE; counter, bit index and shift register 0; PAR_OUT 0; PAR_VALID 0; FRAME_ERR 0; BUSY 0. Both synchroniser flops reset to 1, so no spurious edge is seen out of reset.
- RESET asserted mid-frame aborts the frame and emits no strobe. PAR_OUT returns to 0.

## Timing
- All outputs are registered.
- Latency: let cycle 0 be the edge at which synchroniser flop 1 first captures the start bit low. PAR_VALID (or FRAME_ERR) is high exactly 2 + floor(CLKS_PER_BIT/2) + (DATA_W+1)·CLKS_PER_BIT cycles later.
  - Example: DATA_W=8, CLKS_PER_BIT=8 gives cycle 78.
- BUSY rises the cycle after the edge is detected. BUSY falls on the cycle after the strobe, or on the cycle after a START-phase glitch abort.
- Back-to-back frames: a falling edge that arrives in the cycle right after the strobe is accepted. The receiver therefore tolerates a stop bit as short as half a bit period plus 3 cycles.
- Bit-period counter width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps.
- Bit-index width: $clog2(DATA_W+1).

## Structure
- Shared package `s2p_pkg`:
  - state enum (IDLE/START/DATA/STOP);
  - default constants DATA_W_DEF=8 and CLKS_PER_BIT_DEF=434.
- The top-level serial-to-parallel design imports the same package for its display and LED mapping.
- One sub-module: `s2p_sync2`, a generic 2-flop synchroniser with a parameterised reset value. It is reused for the KEY inputs at the top level.
- The FSM, counter and shift register stay inline in `s2p_uart_deserializer`.

## Test plan
Benches run with DATA_W=8 and CLKS_PER_BIT=8.
- Reset, then idle line: outputs all 0, BUSY=0, and no strobes over 200 cycles.
- Send 0xA5 with a correct stop bit: PAR_OUT=0xA5 and PAR_VALID=1 for exactly one cycle, at cycle 78 relative to start capture; BUSY returns to 0 on the next cycle.
- Send 0x3C, then 0x81 with a minimal gap (stop bit of 8 cycles): two PAR_VALID pulses in order, with PAR_OUT=0x3C then PAR_OUT=0x81, and no FRAME_ERR.
- Send 0xFF with the stop bit low, then hold the line low for 100 cycles: one FRAME_ERR pulse, PAR_OUT keeps its previous value, and no further activity until the line goes high and then falls again.
- Drive a 2-cycle low glitch on an idle line: BUSY pulses, the FSM returns to IDLE after the half-bit check, and there is no PAR_VALID or FRAME_ERR.
- Assert RESET for one cycle at data bit 4 of an active frame: PAR_OUT=0, no strobes, and the next clean frame 0x5A is received correctly.
